// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC0 = 2'b01,
    ACC1 = 2'b10
  } lsu_state_e;

  localparam int DATA_W = 32;

  // Unshifted byte-lane mask; the reserved size yields no lanes.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      MEM_BYTE: size_mask = 8'h01;
      MEM_HALF: size_mask = 8'h03;
      MEM_WORD: size_mask = 8'h0F;
      default:  size_mask = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-side request/response and memory port B signals of the LSU.
interface lsu_if #(
  parameter int DEPTH = 10
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_we_i;
  logic [1:0]       req_size_i;
  logic             req_unsigned_i;
  logic [31:0]      req_addr_i;
  logic [31:0]      req_wdata_i;
  logic             rsp_valid_o;
  logic [31:0]      rsp_rdata_o;
  logic             rsp_err_o;
  logic             mem_en_o;
  logic [DEPTH-1:0] mem_addr_o;
  logic [3:0]       mem_wsel_byte_o;
  logic [31:0]      mem_wdata_o;
  logic [31:0]      mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output mem_en_o, mem_addr_o, mem_wsel_byte_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  mem_en_o, mem_addr_o, mem_wsel_byte_o, mem_wdata_o
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane alignment: byte mask, store-data shift, load shift and extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] lo_word_i,
  input  logic [31:0] hi_word_i,
  output logic [7:0]  mask_o,
  output logic        split_o,
  output logic [31:0] wdata_lo_o,
  output logic [31:0] wdata_hi_o,
  output logic [31:0] rdata_o
);

  logic [4:0]  sh_amt;
  logic [63:0] wdata_sh;

  function automatic logic [31:0] extend(input logic [63:0] pair, input logic [4:0] sh,
                                         input logic [1:0] size, input logic uns);
    logic [31:0] raw;
    raw = 32'(pair >> sh);
    case (size)
      MEM_BYTE: extend = {{24{~uns & raw[7]}}, raw[7:0]};
      MEM_HALF: extend = {{16{~uns & raw[15]}}, raw[15:0]};
      MEM_WORD: extend = raw;
      default:  extend = 32'h0;
    endcase
  endfunction

  always_comb begin
    sh_amt     = {off_i, 3'b000};
    mask_o     = size_mask(size_i) << off_i;
    split_o    = |mask_o[7:4];
    wdata_sh   = {32'h0, wdata_i} << sh_amt;
    wdata_lo_o = wdata_sh[31:0];
    wdata_hi_o = wdata_sh[63:32];
    rdata_o    = extend({hi_word_i, lo_word_i}, sh_amt, size_i, uns_i);
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request per handshake, split into one or two word accesses.
module lsu
  import lsu_pkg::*;
#(
  parameter int DEPTH            = 10,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic  clk_i,
  input  logic  rstn_i,
  lsu_if.slave  bus
);

  lsu_state_e       state_q, state_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;

  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [1:0]       off_q, off_d;
  logic [DEPTH-1:0] widx_q, widx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      word0_q, word0_d;

  logic             mem_en;
  logic [DEPTH-1:0] mem_addr;
  logic [3:0]       mem_wsel;
  logic [31:0]      mem_wdata;
  logic [31:0]      lo_word, hi_word;
  logic [7:0]       mask;
  logic             split, acc_err;
  logic [31:0]      wdata_lo, wdata_hi, ext_rdata;

  lsu_align u_align (
    .size_i     (size_q),
    .off_i      (off_q),
    .uns_i      (uns_q),
    .wdata_i    (wdata_q),
    .lo_word_i  (lo_word),
    .hi_word_i  (hi_word),
    .mask_o     (mask),
    .split_o    (split),
    .wdata_lo_o (wdata_lo),
    .wdata_hi_o (wdata_hi),
    .rdata_o    (ext_rdata)
  );

  assign acc_err = (size_q == 2'b11) || (split && !ALLOW_MISALIGNED);

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    widx_d      = widx_q;
    wdata_d     = wdata_q;
    word0_d     = word0_q;
    mem_en      = 1'b0;
    mem_addr    = '0;
    mem_wsel    = 4'h0;
    mem_wdata   = 32'h0;
    lo_word     = word0_q;
    hi_word     = 32'h0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          we_d    = bus.req_we_i;
          size_d  = bus.req_size_i;
          uns_d   = bus.req_unsigned_i;
          off_d   = bus.req_addr_i[1:0];
          widx_d  = bus.req_addr_i[DEPTH+1:2];
          wdata_d = bus.req_wdata_i;
          state_d = ACC0;
        end
      end
      ACC0: begin
        lo_word = bus.mem_rdata_i;
        if (acc_err) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
        end else begin
          mem_en    = 1'b1;
          mem_addr  = widx_q;
          mem_wsel  = we_q ? mask[3:0] : 4'h0;
          mem_wdata = wdata_lo;
          word0_d   = bus.mem_rdata_i;
          if (split && ALLOW_MISALIGNED) begin
            state_d = ACC1;
          end else begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = we_q ? 32'h0 : ext_rdata;
          end
        end
      end
      ACC1: begin
        // Second word wraps modulo the memory depth.
        hi_word     = bus.mem_rdata_i;
        mem_en      = 1'b1;
        mem_addr    = widx_q + DEPTH'(1);
        mem_wsel    = we_q ? mask[7:4] : 4'h0;
        mem_wdata   = wdata_hi;
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = we_q ? 32'h0 : ext_rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Request and first-word datapath registers
  always_ff @(posedge clk_i) begin
    we_q    <= we_d;
    size_q  <= size_d;
    uns_q   <= uns_d;
    off_q   <= off_d;
    widx_q  <= widx_d;
    wdata_q <= wdata_d;
    word0_q <= word0_d;
  end

  assign bus.req_ready_o     = (state_q == IDLE);
  assign bus.rsp_valid_o     = rsp_valid_q;
  assign bus.rsp_err_o       = rsp_err_q;
  assign bus.rsp_rdata_o     = rsp_rdata_q;
  assign bus.mem_en_o        = mem_en;
  assign bus.mem_addr_o      = mem_addr;
  assign bus.mem_wsel_byte_o = mem_wsel;
  assign bus.mem_wdata_o     = mem_wdata;

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: two instances (misaligned allowed / rejected) on one shared memory.
module tb_lsu;

  localparam int DEPTH = 10;
  localparam int NW    = 1 << DEPTH;
  localparam int NB    = 4 * NW;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  lsu_if #(.DEPTH(DEPTH)) b0 ();
  lsu_if #(.DEPTH(DEPTH)) b1 ();

  lsu #(.DEPTH(DEPTH), .ALLOW_MISALIGNED(1'b1)) dut0 (.clk_i(clk), .rstn_i(rstn), .bus(b0));
  lsu #(.DEPTH(DEPTH), .ALLOW_MISALIGNED(1'b0)) dut1 (.clk_i(clk), .rstn_i(rstn), .bus(b1));

  // Shared word memory with combinational read; the bench's own writes use a backdoor port.
  logic [31:0] mem [NW];
  logic        bd_we = 1'b0;
  logic [DEPTH-1:0] bd_addr = '0;
  logic [31:0] bd_data = 32'h0;

  assign b0.mem_rdata_i = mem[b0.mem_addr_o];
  assign b1.mem_rdata_i = mem[b1.mem_addr_o];

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (b0.mem_en_o)
      for (int k = 0; k < 4; k++) if (b0.mem_wsel_byte_o[k]) mem[b0.mem_addr_o][8*k +: 8] <= b0.mem_wdata_o[8*k +: 8];
    if (b1.mem_en_o)
      for (int k = 0; k < 4; k++) if (b1.mem_wsel_byte_o[k]) mem[b1.mem_addr_o][8*k +: 8] <= b1.mem_wdata_o[8*k +: 8];
  end

  // Reference model: flat little-endian byte array addressed modulo its size.
  logic [7:0] rb [NB];

  int n_cmp = 0;
  int n_bad = 0;

  int          o_lat, o_nacc;
  logic [31:0] o_rdata;
  logic        o_err;
  logic [DEPTH-1:0] acc_addr [2];
  logic [3:0]  acc_wsel [2];
  logic [31:0] acc_wdata [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] s, input bit u);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = size_bytes(s);
    for (int i = 0; i < n; i++) v = v | (32'(rb[(a + i) % NB]) << (8 * i));
    if (n == 1) return u ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
    if (n == 2) return u ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    for (int i = 0; i < size_bytes(s); i++) rb[(a + i) % NB] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
  endfunction

  task automatic set_word(input int w, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = DEPTH'(w); bd_data = d;
    for (int k = 0; k < 4; k++) rb[4*w+k] = d[8*k +: 8];
    @(posedge clk); #1 bd_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic drive(input int inst, input logic v, input bit we, input logic [1:0] size,
                       input bit uns, input logic [31:0] addr, input logic [31:0] wd);
    if (inst == 0) begin
      b0.req_valid_i = v; b0.req_we_i = we; b0.req_size_i = size;
      b0.req_unsigned_i = uns; b0.req_addr_i = addr; b0.req_wdata_i = wd;
    end else begin
      b1.req_valid_i = v; b1.req_we_i = we; b1.req_size_i = size;
      b1.req_unsigned_i = uns; b1.req_addr_i = addr; b1.req_wdata_i = wd;
    end
  endtask

  // Issue one request at the current negedge and wait (bounded) for its response.
  task automatic do_op(input int inst, input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    int n, w;
    bit split, errx;
    logic [31:0] exp_rd;
    logic en_s, rv_s;
    n      = size_bytes(size);
    split  = (n > 0) && (int'(addr[1:0]) + n > 4);
    errx   = (size == 2'd3) || (split && inst == 1);
    exp_rd = (we || errx) ? 32'h0 : ref_load(addr, size, uns);
    o_lat = 0; o_nacc = 0; o_rdata = 32'hx; o_err = 1'bx;
    for (int k = 0; k < 2; k++) begin acc_addr[k] = '0; acc_wsel[k] = 4'h0; acc_wdata[k] = 32'h0; end
    drive(inst, 1'b1, we, size, uns, addr, wd);
    check("req_ready", {31'h0, (inst == 1) ? b1.req_ready_o : b0.req_ready_o}, 32'h1);
    @(posedge clk);
    #1 drive(inst, 1'b0, 1'b0, 2'd0, 1'b0, $urandom, $urandom);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      en_s = (inst == 1) ? b1.mem_en_o : b0.mem_en_o;
      rv_s = (inst == 1) ? b1.rsp_valid_o : b0.rsp_valid_o;
      if (en_s) begin
        if (o_nacc < 2) begin
          acc_addr[o_nacc]  = (inst == 1) ? b1.mem_addr_o : b0.mem_addr_o;
          acc_wsel[o_nacc]  = (inst == 1) ? b1.mem_wsel_byte_o : b0.mem_wsel_byte_o;
          acc_wdata[o_nacc] = (inst == 1) ? b1.mem_wdata_o : b0.mem_wdata_o;
        end
        o_nacc++;
      end
      if (rv_s) begin
        o_lat   = c;
        o_rdata = (inst == 1) ? b1.rsp_rdata_o : b0.rsp_rdata_o;
        o_err   = (inst == 1) ? b1.rsp_err_o : b0.rsp_err_o;
        break;
      end
    end
    check("rsp_latency", o_lat, (errx || !split) ? 32'd2 : 32'd3);
    check("mem_accesses", o_nacc, errx ? 32'd0 : split ? 32'd2 : 32'd1);
    check("rsp_err", {31'h0, o_err}, {31'h0, errx});
    check("rsp_rdata", o_rdata, exp_rd);
    if (!errx && we) ref_store(addr, size, wd);
    if (we) begin
      w = int'(addr[DEPTH+1:2]);
      check("mem_word_lo", mem[w], ref_word(w));
      check("mem_word_hi", mem[(w + 1) % NW], ref_word((w + 1) % NW));
    end else if (o_nacc > 0) begin
      check("load_wsel", {28'h0, acc_wsel[0] | acc_wsel[1]}, 32'h0);
    end
  endtask

  initial begin
    logic [1:0] rs;
    logic [31:0] ra;
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    for (int w = 0; w < NW; w++) set_word(w, $urandom);

    // Reset state while rstn is held low
    check("rst_ready", {31'h0, b0.req_ready_o}, 32'h1);
    check("rst_rsp_valid", {31'h0, b0.rsp_valid_o}, 32'h0);
    check("rst_rsp_err", {31'h0, b0.rsp_err_o}, 32'h0);
    check("rst_rsp_rdata", b0.rsp_rdata_o, 32'h0);
    check("rst_mem_en", {31'h0, b0.mem_en_o | b1.mem_en_o}, 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    // Byte loads, signed and unsigned
    set_word(16'h10, 32'h8899AABB);
    do_op(0, 1'b0, 2'd0, 1'b0, 32'h41, 32'h0);
    check("lb_signed", o_rdata, 32'hFFFFFFAA);
    do_op(0, 1'b0, 2'd0, 1'b1, 32'h41, 32'h0);
    check("lb_unsigned", o_rdata, 32'h000000AA);

    // Half store into upper lanes
    do_op(0, 1'b1, 2'd1, 1'b0, 32'h42, 32'h00001234);
    check("sh_addr", {22'h0, acc_addr[0]}, 32'h10);
    check("sh_wsel", {28'h0, acc_wsel[0]}, 32'hC);
    check("sh_wdata", acc_wdata[0], 32'h12340000);
    check("sh_word", mem[16'h10], 32'h1234AABB);

    // Misaligned word load across two words
    set_word(16'h10, 32'h44332211);
    set_word(16'h11, 32'h88776655);
    do_op(0, 1'b0, 2'd2, 1'b0, 32'h43, 32'h0);
    check("lw_split_a0", {22'h0, acc_addr[0]}, 32'h10);
    check("lw_split_a1", {22'h0, acc_addr[1]}, 32'h11);
    check("lw_split_data", o_rdata, 32'h77665544);

    // Misaligned word store wrapping from the last word to word 0
    do_op(0, 1'b1, 2'd2, 1'b0, 32'h0FFF, 32'hDEADBEEF);
    check("sw_wrap_a0", {22'h0, acc_addr[0]}, 32'h3FF);
    check("sw_wrap_wsel0", {28'h0, acc_wsel[0]}, 32'h8);
    check("sw_wrap_a1", {22'h0, acc_addr[1]}, 32'h0);
    check("sw_wrap_wsel1", {28'h0, acc_wsel[1]}, 32'h7);
    check("sw_wrap_lane3", {24'h0, mem[10'h3FF][31:24]}, 32'hEF);
    check("sw_wrap_lanes012", {8'h0, mem[0][23:0]}, 32'hDEADBE);

    // Rejected misaligned access and reserved size
    do_op(1, 1'b0, 2'd1, 1'b0, 32'h03, 32'h0);
    check("na_err", {31'h0, o_err}, 32'h1);
    check("na_rdata", o_rdata, 32'h0);
    do_op(0, 1'b0, 2'd3, 1'b0, 32'h40, 32'h0);
    check("rsv0_err", {31'h0, o_err}, 32'h1);
    do_op(1, 1'b1, 2'd3, 1'b0, 32'h40, 32'h12345678);
    check("rsv1_err", {31'h0, o_err}, 32'h1);

    // Reset during ACC1 of a split store
    set_word(16'h20, 32'h11111111);
    set_word(16'h21, 32'h22222222);
    do_op(0, 1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
    drive(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h81, 32'hCAFEF00D);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1 check("acc1_en", {31'h0, b0.mem_en_o}, 32'h1);
    #1 rstn = 1'b0;
    #1;
    check("mid_rst_en", {31'h0, b0.mem_en_o}, 32'h0);
    check("mid_rst_ready", {31'h0, b0.req_ready_o}, 32'h1);
    check("mid_rst_rdata", b0.rsp_rdata_o, 32'h0);
    check("mid_rst_err", {31'h0, b0.rsp_err_o}, 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("mid_rst_no_rsp", {31'h0, b0.rsp_valid_o}, 32'h0);
    end
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_no_rsp", {31'h0, b0.rsp_valid_o}, 32'h0);
    for (int i = 0; i < 3; i++) rb[32'h81 + i] = 8'(32'hCAFEF00D >> (8 * i));
    do_op(0, 1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
    check("post_rst_first_half", o_rdata, 32'hFEF00D11);
    do_op(0, 1'b0, 2'd2, 1'b0, 32'h84, 32'h0);
    check("post_rst_second_untouched", o_rdata, 32'h22222222);

    // Randomized traffic on both instances, back to back
    for (int t = 0; t < 240; t++) begin
      rs = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ra = ($urandom & 32'hFFFF_F000) |
           (($urandom_range(0, 3) == 0) ? (32'hFF8 + $urandom_range(0, 7)) : (32'h40 + $urandom_range(0, 31)));
      do_op((t % 5 == 4) ? 1 : 0, 1'($urandom), rs, 1'($urandom), ra, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
